// File: rtl/ik_seq_pkg.sv
// Shared types and constants for the ik_swift iteration sequencer.
//   ik_state_e : 4-bit encoded sequencer state (IDLE must stay at 0, it is the reset value)
//   MM_JJT     : mat_mult operand select for J*J^T
//   MM_PINV    : mat_mult operand select for J^T*inv
//   is_busy()  : true in any state that is part of an active solve
//   is_stage() : true in states that wait on a sub-block done (watchdog runs there)
package ik_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_JAC   = 4'd1,
      ST_MM1   = 4'd2,
      ST_INV   = 4'd3,
      ST_MM2   = 4'd4,
      ST_AM    = 4'd5,
      ST_UPD   = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERROR = 4'd8
   } ik_state_e;

   localparam logic MM_JJT  = 1'b0;
   localparam logic MM_PINV = 1'b1;

   function automatic logic is_busy(input ik_state_e s);
      return !(s == ST_IDLE || s == ST_DONE || s == ST_ERROR);
   endfunction

   function automatic logic is_stage(input ik_state_e s);
      return (s == ST_JAC || s == ST_MM1 || s == ST_INV || s == ST_MM2 || s == ST_AM);
   endfunction

endpackage

// File: rtl/ik_sequencer_if.sv
// Handshake bundle between the iteration sequencer and the shared solver datapath.
//   jac_en/jac_done  : full_jacobian enable / completion pulse
//   mm_en/mm_sel/mm_done : mat_mult enable, operand select, completion pulse
//   inv_en/inv_done  : inverse enable / completion pulse
//   am_en/am_done    : array_mult enable / completion pulse
//   theta_we         : commit theta += dtheta
//   err_sq           : squared residual from full_jacobian
// master = sequencer side, slave = datapath side.
interface ik_sequencer_if #(
   parameter int DATA_W = 27
);
   logic              jac_en;
   logic              jac_done;
   logic              mm_en;
   logic              mm_sel;
   logic              mm_done;
   logic              inv_en;
   logic              inv_done;
   logic              am_en;
   logic              am_done;
   logic              theta_we;
   logic [DATA_W-1:0] err_sq;

   modport master (
      output jac_en, mm_en, mm_sel, inv_en, am_en, theta_we,
      input  jac_done, mm_done, inv_done, am_done, err_sq
   );

   modport slave (
      input  jac_en, mm_en, mm_sel, inv_en, am_en, theta_we,
      output jac_done, mm_done, inv_done, am_done, err_sq
   );
endinterface

// File: rtl/ik_stage_watchdog.sv
// Per-stage hang detector shared by all sequencer stages.
//   clk, reset : clock, synchronous active-high reset
//   clr        : reload; asserted in the cycle before a stage is entered
//   tick       : high while a stage is waiting on its done
//   expired    : high in the TIMEOUT-th cycle of a stage (cycle index TIMEOUT-1)
// Implemented as a down-counter loaded with TIMEOUT-1 and a terminal-count compare,
// which is equivalent to counting up from 0 to TIMEOUT-1.
module ik_stage_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = TC_LOAD;
      end else if (tick && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Gated by tick so the reset value of 0 never reads as an expiry outside a stage.
   assign expired = tick && (cnt_q == '0);

endmodule

// File: rtl/ik_sequencer.sv
// Iteration controller for the ik_swift solver. Steps the shared datapath once per
// IK iteration (jacobian, J*J^T, inverse, J^T*inv, dtheta, theta write), checks
// convergence, counts iterations and reports the outcome to the host.
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin solve (accepted in IDLE, DONE, ERROR)
//   max_iter,tol : iteration limit (0 acts as 1) and convergence threshold, sampled on start
//   dp           : datapath handshake bundle (master side)
//   busy         : solve in progress
//   done         : one-cycle pulse at solve end
//   converged    : residual dropped below tol; valid from done until next start
//   error        : sticky watchdog flag
//   iter_count   : completed iterations in this solve
//   state        : encoded state for debug
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start after reset
// JAC      | full_jacobian running, err_sq checked on jac_done
// MM1      | mat_mult J*J^T
// INV      | inverse
// MM2      | mat_mult J^T*inv
// AM       | array_mult producing dtheta
// UPD      | one cycle: theta_we, iter_count++, limit check
// DONE     | solve finished (converged or limit), waits for start
// ERROR    | stage watchdog expired, waits for start
module ik_sequencer
   import ik_seq_pkg::*;
#(
   parameter int DATA_W  = 27,
   parameter int ITER_W  = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ITER_W-1:0] max_iter,
   input  logic [DATA_W-1:0] tol,
   ik_sequencer_if.master    dp,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic              error,
   output logic [ITER_W-1:0] iter_count,
   output logic [3:0]        state
);

   ik_state_e         state_q,      state_d;
   logic [ITER_W-1:0] max_iter_q,   max_iter_d;
   logic [DATA_W-1:0] tol_q,        tol_d;
   logic [ITER_W-1:0] iter_count_q, iter_count_d;
   logic              converged_q,  converged_d;
   logic              error_q,      error_d;
   logic              jac_en_q,     jac_en_d;
   logic              mm_en_q,      mm_en_d;
   logic              mm_sel_q,     mm_sel_d;
   logic              inv_en_q,     inv_en_d;
   logic              am_en_q,      am_en_d;
   logic              theta_we_q,   theta_we_d;
   logic              busy_q,       busy_d;
   logic              done_q,       done_d;

   logic              stage_done;
   logic              wd_clr;
   logic              wd_tick;
   logic              wd_expired;

   // Only the done of the current stage is looked at; the others are ignored.
   always_comb begin
      stage_done = 1'b0;
      case (state_q)
         ST_JAC:  stage_done = dp.jac_done;
         ST_MM1:  stage_done = dp.mm_done;
         ST_INV:  stage_done = dp.inv_done;
         ST_MM2:  stage_done = dp.mm_done;
         ST_AM:   stage_done = dp.am_done;
         default: stage_done = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      max_iter_d   = max_iter_q;
      tol_d        = tol_q;
      iter_count_d = iter_count_q;
      converged_d  = converged_q;
      error_d      = error_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d      = ST_JAC;
               max_iter_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
               tol_d        = tol;
               iter_count_d = '0;
               converged_d  = 1'b0;
               error_d      = 1'b0;
            end
         end
         ST_UPD: begin
            iter_count_d = iter_count_q + ITER_W'(1);
            state_d      = (iter_count_d == max_iter_q) ? ST_DONE : ST_JAC;
         end
         ST_JAC, ST_MM1, ST_INV, ST_MM2, ST_AM: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (stage_done) begin
               case (state_q)
                  ST_JAC: begin
                     if (dp.err_sq < tol_q) begin
                        state_d     = ST_DONE;
                        converged_d = 1'b1;
                     end else begin
                        state_d = ST_MM1;
                     end
                  end
                  ST_MM1:  state_d = ST_INV;
                  ST_INV:  state_d = ST_MM2;
                  ST_MM2:  state_d = ST_AM;
                  default: state_d = ST_UPD;
               endcase
            end else if (wd_expired) begin
               state_d     = ST_ERROR;
               error_d     = 1'b1;
               converged_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs decode from the next state so they are registered alongside it.
      jac_en_d   = (state_d == ST_JAC);
      mm_en_d    = (state_d == ST_MM1) || (state_d == ST_MM2);
      mm_sel_d   = (state_d == ST_MM2) ? MM_PINV : MM_JJT;
      inv_en_d   = (state_d == ST_INV);
      am_en_d    = (state_d == ST_AM);
      theta_we_d = (state_d == ST_UPD);
      busy_d     = is_busy(state_d);
      done_d     = ((state_d == ST_DONE) || (state_d == ST_ERROR)) && (state_d != state_q);
   end

   // Reload on every state change so each stage starts with a full budget.
   assign wd_clr  = (state_d != state_q);
   assign wd_tick = is_stage(state_q);

   ik_stage_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wd_clr),
      .tick    (wd_tick),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         max_iter_q   <= '0;
         tol_q        <= '0;
         iter_count_q <= '0;
         converged_q  <= 1'b0;
         error_q      <= 1'b0;
         jac_en_q     <= 1'b0;
         mm_en_q      <= 1'b0;
         mm_sel_q     <= 1'b0;
         inv_en_q     <= 1'b0;
         am_en_q      <= 1'b0;
         theta_we_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         max_iter_q   <= max_iter_d;
         tol_q        <= tol_d;
         iter_count_q <= iter_count_d;
         converged_q  <= converged_d;
         error_q      <= error_d;
         jac_en_q     <= jac_en_d;
         mm_en_q      <= mm_en_d;
         mm_sel_q     <= mm_sel_d;
         inv_en_q     <= inv_en_d;
         am_en_q      <= am_en_d;
         theta_we_q   <= theta_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign dp.jac_en   = jac_en_q;
   assign dp.mm_en    = mm_en_q;
   assign dp.mm_sel   = mm_sel_q;
   assign dp.inv_en   = inv_en_q;
   assign dp.am_en    = am_en_q;
   assign dp.theta_we = theta_we_q;

   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = converged_q;
   assign error      = error_q;
   assign iter_count = iter_count_q;
   assign state      = state_q;

endmodule

// File: tb/tb_ik_sequencer.sv
// Directed bench for ik_sequencer with stub sub-blocks of programmable done latency.
// Expected solve outcomes are queued when a solve is started; a negedge monitor
// pops and compares them whenever the DUT pulses done.
module tb_ik_sequencer;
   import ik_seq_pkg::*;

   localparam int DATA_W  = 27;
   localparam int ITER_W  = 8;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ITER_W-1:0] max_iter;
   logic [DATA_W-1:0] tol;
   logic              busy, done, converged, error;
   logic [ITER_W-1:0] iter_count;
   logic [3:0]        state;

   ik_sequencer_if #(.DATA_W(DATA_W)) dp ();

   ik_sequencer #(
      .DATA_W  (DATA_W),
      .ITER_W  (ITER_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .max_iter   (max_iter),
      .tol        (tol),
      .dp         (dp),
      .busy       (busy),
      .done       (done),
      .converged  (converged),
      .error      (error),
      .iter_count (iter_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // stub sub-blocks: done in the lat-th cycle of enable, lat=0 means never
   int lat_jac, lat_mm, lat_inv, lat_am;
   int cnt_jac = 0, cnt_mm = 0, cnt_inv = 0, cnt_am = 0;

   always @(posedge clk) begin
      cnt_jac <= dp.jac_en ? cnt_jac + 1 : 0;
      cnt_mm  <= dp.mm_en  ? cnt_mm  + 1 : 0;
      cnt_inv <= dp.inv_en ? cnt_inv + 1 : 0;
      cnt_am  <= dp.am_en  ? cnt_am  + 1 : 0;
   end

   assign dp.jac_done = dp.jac_en && (lat_jac != 0) && (cnt_jac == lat_jac - 1);
   assign dp.mm_done  = dp.mm_en  && (lat_mm  != 0) && (cnt_mm  == lat_mm  - 1);
   assign dp.inv_done = dp.inv_en && (lat_inv != 0) && (cnt_inv == lat_inv - 1);
   assign dp.am_done  = dp.am_en  && (lat_am  != 0) && (cnt_am  == lat_am  - 1);

   typedef struct packed {
      logic       conv;
      logic       err;
      logic [7:0] iters;
      logic [7:0] thetas;
      logic [7:0] inv_run;
   } exp_t;

   exp_t  exp_q[$];
   string seq_q[$];

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got '%s' expected '%s' (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push_exp(input logic c, input logic e, input int it, input int th,
                           input int ir, input string sq);
      exp_t x;
      x.conv    = c;
      x.err     = e;
      x.iters   = 8'(it);
      x.thetas  = 8'(th);
      x.inv_run = 8'(ir);
      exp_q.push_back(x);
      seq_q.push_back(sq);
   endtask

   // monitor: J/M/I/P/A per enable rise (P = mat_mult with sel=PINV)
   string seq = "";
   int    thetas = 0;
   int    inv_run = 0;
   int    last_jd = -100;
   logic  prev_jac = 0, prev_mm = 0, prev_inv = 0, prev_am = 0, prev_done = 0;

   always @(negedge clk) begin
      if (reset) begin
         seq     = "";
         thetas  = 0;
         inv_run = 0;
      end else begin
         if (dp.jac_en && !prev_jac) seq = {seq, "J"};
         if (dp.mm_en && !prev_mm) begin
            if (dp.mm_sel) seq = {seq, "P"};
            else           seq = {seq, "M"};
         end
         if (dp.inv_en && !prev_inv) seq = {seq, "I"};
         if (dp.am_en && !prev_am) seq = {seq, "A"};
         if (dp.inv_en) inv_run = prev_inv ? inv_run + 1 : 1;
         if (dp.theta_we) thetas++;
         if (dp.jac_en && dp.jac_done) last_jd = cyc;
         if (prev_done) chk("done_one_cycle", done, 0);
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t  x;
               string s;
               x = exp_q.pop_front();
               s = seq_q.pop_front();
               chk("converged", converged, x.conv);
               chk("error", error, x.err);
               chk("iter_count", iter_count, x.iters);
               chk("theta_we_pulses", thetas, x.thetas);
               chk("busy_at_done", busy, 0);
               chk_str("enable_sequence", seq, s);
               if (x.inv_run != 0) chk("inv_en_cycles", inv_run, x.inv_run);
               if (x.conv) chk("jac_done_to_done", cyc - last_jd, 1);
            end
            seq     = "";
            thetas  = 0;
            inv_run = 0;
         end
      end
      prev_jac  = dp.jac_en;
      prev_mm   = dp.mm_en;
      prev_inv  = dp.inv_en;
      prev_am   = dp.am_en;
      prev_done = done;
   end

   task automatic start_solve(input int mi, input int tl);
      start    = 1'b1;
      max_iter = ITER_W'(mi);
      tol      = DATA_W'(tl);
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0;
      int k;
      n0 = done_cnt;
      k  = 0;
      while (done_cnt == n0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (done_cnt == n0) chk("wait_done_timeout", 0, 1);
   endtask

   initial begin
      int k;
      reset     = 1'b1;
      start     = 1'b0;
      max_iter  = '0;
      tol       = '0;
      dp.err_sq = '0;
      lat_jac = 5; lat_mm = 5; lat_inv = 5; lat_am = 5;

      // 1: reset state, start under reset ignored
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_iter_count", iter_count, 0);
      chk("rst_outputs", {busy, done, converged, error, dp.jac_en, dp.mm_en, dp.mm_sel,
                          dp.inv_en, dp.am_en, dp.theta_we}, 0);
      start = 1'b1; max_iter = 8'd3; tol = 27'd100;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_reset_state", state, 0);
      chk("start_in_reset_busy", busy, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", state, 0);

      // 2: immediate convergence
      lat_jac = 4;
      dp.err_sq = 27'd50;
      push_exp(1, 0, 0, 0, 0, "J");
      start_solve(1, 100);
      chk("busy_after_start", busy, 1);
      wait_done(100);

      // 3: iteration limit
      lat_jac = 5;
      dp.err_sq = 27'd1000;
      push_exp(0, 0, 3, 3, 5, "JMIPAJMIPAJMIPA");
      start_solve(3, 10);
      wait_done(500);

      // 4: converges on the second jacobian
      push_exp(1, 0, 1, 1, 5, "JMIPAJ");
      start_solve(5, 10);
      k = 0;
      while (!(dp.jac_en && dp.jac_done) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) chk("wait_first_jac_done_timeout", 0, 1);
      @(posedge clk); #1;
      dp.err_sq = 27'd5;
      wait_done(500);

      // 5: inverse hangs -> watchdog, then a new start clears error
      dp.err_sq = 27'd1000;
      lat_inv = 0;
      push_exp(0, 1, 0, 0, 16, "JMI");
      start_solve(3, 10);
      wait_done(200);
      repeat (3) @(posedge clk);
      #1;
      chk("error_sticky", error, 1);
      chk("error_state", state, ST_ERROR);
      lat_inv = 5;
      push_exp(0, 0, 1, 1, 5, "JMIPA");
      start_solve(1, 10);
      chk("error_cleared_by_start", error, 0);
      chk("state_jac_after_start", state, ST_JAC);
      wait_done(300);

      // 6: max_iter=0 acts as 1, start during MM1 ignored
      push_exp(0, 0, 1, 1, 5, "JMIPA");
      start_solve(0, 10);
      k = 0;
      while (!(dp.mm_en && !dp.mm_sel) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) chk("wait_mm1_timeout", 0, 1);
      start = 1'b1; max_iter = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(300);

      // reset during INV
      start_solve(2, 10);
      k = 0;
      while (!dp.inv_en && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) chk("wait_inv_timeout", 0, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_mid_state", state, 0);
      chk("reset_mid_inv_en", dp.inv_en, 0);
      chk("reset_mid_busy", busy, 0);
      chk("reset_mid_iter_count", iter_count, 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_mid_reset", state, 0);
      chk("pending_expectations", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
